// File: rtl/cache_pkg.sv
// Shared types and constants for the shift-in lookup cache fill controller.
package cache_pkg;

  localparam int unsigned DEF_AW   = 32;
  localparam int unsigned DEF_DW   = 32;
  localparam int unsigned LK_DEPTH = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MEM_RD = 3'd1,
    MEM_WR = 3'd2,
    FILL   = 3'd3,
    RESP   = 3'd4
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// W-bit incrementer that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  // NOTE: state registers take non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cache_fill_ctrl.sv
// Fill/update controller for the shift-in lookup: resolves loads (hit or memory fetch),
// writes stores through to memory, and shifts every fetched/stored word into the lookup.
module cache_fill_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned AW      = DEF_AW,
  parameter int unsigned DW      = DEF_DW,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CW      = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          REQ,
  input  logic          REQ_WE,
  input  logic [AW-1:0] REQ_ADDR,
  input  logic [DW-1:0] REQ_WDATA,
  output logic          BUSY,
  output logic          RESP_VALID,
  output logic [DW-1:0] RESP_DATA,
  output logic          ERR,
  output logic [AW-1:0] LK_ADDR,
  output logic [DW-1:0] LK_DIN,
  output logic          LK_WE,
  input  logic          LK_FOUND,
  input  logic [DW-1:0] LK_DOUT,
  output logic          MEM_REQ,
  output logic          MEM_WE,
  output logic [AW-1:0] MEM_ADDR,
  output logic [DW-1:0] MEM_WDATA,
  input  logic          MEM_ACK,
  input  logic [DW-1:0] MEM_RDATA,
  output logic [CW-1:0] HIT_CNT,
  output logic [CW-1:0] MISS_CNT
);

  localparam int unsigned      TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0]    TLAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          we_q, we_d;
  logic          err_q, err_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          hit_inc, miss_inc;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      err_q   <= err_d;
      timer_q <= timer_d;
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    we_d     = we_q;
    err_d    = err_q;
    timer_d  = '0;
    hit_inc  = 1'b0;
    miss_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (REQ) begin
          addr_d = REQ_ADDR;
          data_d = REQ_WDATA;
          we_d   = REQ_WE;
          err_d  = 1'b0;
          if (REQ_WE) begin
            state_d = MEM_WR;
          end else if (LK_FOUND) begin
            data_d  = LK_DOUT;
            hit_inc = 1'b1;
            state_d = RESP;
          end else begin
            miss_inc = 1'b1;
            state_d  = MEM_RD;
          end
        end
      end
      MEM_RD, MEM_WR: begin
        // An ACK in the final timer cycle still completes normally.
        if (MEM_ACK) begin
          if (state_q == MEM_RD) data_d = MEM_RDATA;
          state_d = FILL;
        end else if ((TIMEOUT != 0) && (timer_q == TLAST)) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      FILL:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign BUSY       = (state_q != IDLE);
  assign RESP_VALID = (state_q == RESP);
  assign RESP_DATA  = ((state_q == RESP) && !we_q && !err_q) ? data_q : '0;
  assign ERR        = (state_q == RESP) && err_q;
  // Lookup sees the live request address in IDLE so the hit check is same-cycle.
  assign LK_ADDR    = (state_q == IDLE) ? REQ_ADDR : addr_q;
  assign LK_DIN     = data_q;
  assign LK_WE      = (state_q == FILL);
  assign MEM_REQ    = (state_q == MEM_RD) || (state_q == MEM_WR);
  assign MEM_WE     = (state_q == MEM_WR);
  assign MEM_ADDR   = addr_q;
  assign MEM_WDATA  = data_q;

  sat_counter #(.W(CW)) u_hit_cnt (
    .clk   (CLK),
    .rst   (RST),
    .inc_i (hit_inc),
    .cnt_o (HIT_CNT)
  );

  sat_counter #(.W(CW)) u_miss_cnt (
    .clk   (CLK),
    .rst   (RST),
    .inc_i (miss_inc),
    .cnt_o (MISS_CNT)
  );

endmodule

// File: doc/cache_fill_ctrl.md
Name: cache_fill_ctrl

Overview:
Fill/update side of the 32-entry CPU shift-in lookup cache. It owns the lookup write port and generates its WE, ADDR and DIN.
- Read requests: checks the lookup hit result. On a miss it fetches the word from main memory over a request/ack handshake, shifts {addr,data} into the lookup, then responds.
- Stores: written through to memory, then shifted into the lookup (write-allocate). The newest entry always wins.

Parameters:
AW, 32, address width
DW, 32, data width
TIMEOUT, 255, max cycles to wait for MEM_ACK before aborting with ERR (0 = no timeout)
CW, 16, width of hit/miss counters

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous active-high reset
REQ  in  1  CPU request, sampled only when BUSY=0
REQ_WE  in  1  1 = store, 0 = load
REQ_ADDR  in  AW  request address
REQ_WDATA  in  DW  store data
BUSY  out  1  controller not in IDLE
RESP_VALID  out  1  one-cycle completion pulse
RESP_DATA  out  DW  load data, valid with RESP_VALID
ERR  out  1  with RESP_VALID: memory timeout
LK_ADDR  out  AW  lookup address
LK_DIN  out  DW  lookup fill data
LK_WE  out  1  lookup shift-in strobe
LK_FOUND  in  1  lookup hit (combinational from LK_ADDR)
LK_DOUT  in  DW  lookup hit data
MEM_REQ  out  1  memory request, held until MEM_ACK
MEM_WE  out  1  memory write qualifier
MEM_ADDR  out  AW  memory address
MEM_WDATA  out  DW  memory write data
MEM_ACK  in  1  memory completion, one cycle
MEM_RDATA  in  DW  read data, valid with MEM_ACK
HIT_CNT  out  CW  load hits, saturating
MISS_CNT  out  CW  load misses, saturating

Behaviour:
- States: IDLE, MEM_RD, MEM_WR, FILL, RESP.
- Reset (async): state IDLE. All outputs 0: BUSY, RESP_VALID, RESP_DATA, ERR, LK_WE, MEM_REQ, MEM_WE, counters. addr_q, data_q and timer also 0.
- LK_ADDR: equals REQ_ADDR in IDLE, addr_q otherwise. This lets the lookup hit check happen in the same cycle REQ is sampled.
- IDLE, REQ=1: latch addr_q=REQ_ADDR and data_q=REQ_WDATA.
  - Load with LK_FOUND=1: latch data_q=LK_DOUT, HIT_CNT+1, go to RESP. Load-hit latency is 1 cycle (RESP_VALID on the cycle after REQ).
  - Load with LK_FOUND=0: MISS_CNT+1, go to MEM_RD.
  - Store: go to MEM_WR. Stores do not touch the counters.
- MEM_RD: MEM_REQ=1, MEM_WE=0, MEM_ADDR=addr_q. On MEM_ACK, latch data_q=MEM_RDATA and go to FILL.
- MEM_WR: MEM_REQ=1, MEM_WE=1, MEM_ADDR=addr_q, MEM_WDATA=data_q. On MEM_ACK go to FILL.
- Memory handshake: MEM_REQ and its address/data are stable from entry until the MEM_ACK cycle, and drop the cycle after MEM_ACK. MEM_ACK outside MEM_RD/MEM_WR is ignored.
- FILL: LK_WE=1 for exactly one cycle with LK_ADDR=addr_q and LK_DIN=data_q, then go to RESP.
- RESP: RESP_VALID=1 for one cycle. RESP_DATA=data_q for loads; it is don't-care for stores and is driven as 0. Then return to IDLE.
  - BUSY falls in the same cycle the state returns to IDLE.
  - No back-to-back acceptance: REQ is accepted no earlier than the cycle after RESP.
- Timeout (TIMEOUT>0): timer clears on entering MEM_RD/MEM_WR and increments each cycle without ACK.
  - On reaching TIMEOUT: drop MEM_REQ, skip FILL, go to RESP with ERR=1 and RESP_DATA=0. The lookup is not written.
  - ACK arriving in the same cycle the timer hits TIMEOUT wins: normal completion.
- Counters saturate at all-ones.
- Duplicate addresses are permitted in the lookup: every store/fill shifts in a new entry and the newest shadows older ones. No invalidation path.
- RST asserted mid-transaction: immediate return to IDLE with all outputs 0. MEM_REQ drops asynchronously and any in-flight fill is lost.

Decomposition:
- Shared package cache_pkg: state encoding constants (IDLE=0, MEM_RD=1, MEM_WR=2, FILL=3, RESP=4), default AW/DW, and the lookup depth constant 32.
- One natural sub-module: sat_counter (CW-bit saturating incrementer with async reset), instantiated twice for HIT_CNT and MISS_CNT.

Test Plan:
1. Load miss: reset, REQ load 0x100, LK_FOUND=0, memory ACKs 3 cycles later with 0xDEADBEEF -> MEM_REQ held 3 cycles with MEM_WE=0; then one LK_WE pulse (LK_ADDR=0x100, LK_DIN=0xDEADBEEF); RESP_VALID with RESP_DATA=0xDEADBEEF; MISS_CNT=1.
2. Load hit: REQ load 0x100, LK_FOUND=1, LK_DOUT=0xDEADBEEF -> RESP_VALID next cycle with 0xDEADBEEF; no MEM_REQ; no LK_WE; HIT_CNT=1.
3. Store: REQ store 0x200 with data 0x12345678, ACK after 1 cycle -> MEM_WE=1 with MEM_WDATA=0x12345678; LK_WE pulse {0x200,0x12345678}; RESP_VALID with ERR=0; counters unchanged.
4. Timeout: TIMEOUT=4, load miss, no ACK -> MEM_REQ drops after 4 cycles; RESP_VALID with ERR=1 and RESP_DATA=0; no LK_WE.
5. Reset mid-op: RST pulsed while in MEM_RD -> MEM_REQ=0 and BUSY=0 immediately; a late ACK afterwards is ignored; no LK_WE or RESP_VALID.
6. Saturation: CW=2, five load hits -> HIT_CNT stays at 3.
